// File: rtl/reshape_cmd_sequencer_if.sv
// Command-push and reshape-controller signals of the reshape command sequencer.
// The master modport drives commands and controller status. The slave modport is the sequencer.
interface reshape_cmd_sequencer_if;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic       cmd_ready;
    logic [3:0] Control_Reshape;
    logic [7:0] State;
    logic       Next_Reg;

    modport master (
        output cmd_valid,
        output cmd_op,
        output State,
        output Next_Reg,
        input  cmd_ready,
        input  Control_Reshape
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  State,
        input  Next_Reg,
        output cmd_ready,
        output Control_Reshape
    );
endinterface

// File: rtl/reshape_cmd_sequencer.sv
// Purpose: queues one-hot reshape opcodes and steps the reshape controller through issue/run/release per command.
// Latency: opcode appears on Control_Reshape 1 cycle after IDLE/GAP sees seq_enable with a non-empty queue.
// Backpressure: cmd_ready drops while the queue is full, and pushes are ignored in that state; controller waits have no abort, only a sticky watchdog flag.
module reshape_cmd_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 3,
    parameter int TIMEOUT    = 1048575
) (
    input  logic                      clk,
    input  logic                      rst,
    reshape_cmd_sequencer_if.slave    bus,
    input  logic                      seq_enable,
    input  logic                      err_clear,
    output logic                      busy,
    output logic                      done_pulse,
    output logic                      drain_irq,
    output logic [7:0]                cmd_count,
    output logic [ADDR_W:0]           fifo_level,
    output logic                      err_illegal,
    output logic                      err_timeout
);
    localparam int                WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [WD_W-1:0]   WD_MAX   = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_RUN,
        S_RELEASE,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic                cmd_fire, op_onehot, push, pop, illegal_push;
    logic [3:0]          op_reg, op_d, ctrl_d;
    logic [WD_W-1:0]     wd_cnt, wd_d;
    logic                waiting, timeout_set;

    assign bus.cmd_ready = (fifo_level != FULL_LVL);
    assign cmd_fire      = bus.cmd_valid & bus.cmd_ready;
    assign op_onehot     = $onehot(bus.cmd_op);
    assign push          = cmd_fire & op_onehot;
    assign illegal_push  = cmd_fire & ~op_onehot;

    assign busy       = (state_q != S_IDLE);
    assign done_pulse = (state_q == S_GAP);
    assign drain_irq  = done_pulse && (fifo_level == '0);

    // Storage needs no reset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.cmd_op;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (seq_enable && (fifo_level != '0)) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((bus.State[3:0] == op_reg) && (bus.State[7:4] == 4'h0)) begin
                    state_d = S_WAIT_RUN;
                end
            end
            S_WAIT_RUN: begin
                if (bus.State == 8'h0F) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (bus.Next_Reg) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (seq_enable && (fifo_level != '0)) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        op_d = pop ? mem[rd_ptr] : op_reg;

        // Control_Reshape is registered, so it is derived from the state being entered.
        case (state_d)
            S_ISSUE:   ctrl_d = op_d;
            S_RELEASE: ctrl_d = 4'hF;
            default:   ctrl_d = 4'h0;
        endcase

        waiting = (state_q == S_ISSUE) || (state_q == S_WAIT_RUN) || (state_q == S_RELEASE);
        wd_d    = wd_cnt;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (waiting && (wd_cnt != WD_MAX)) begin
            wd_d = wd_cnt + 1'b1;
        end
        timeout_set = waiting && (state_d == state_q) && (wd_d == WD_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q             <= S_IDLE;
            op_reg              <= 4'h0;
            bus.Control_Reshape <= 4'h0;
            wd_cnt              <= '0;
            cmd_count           <= 8'h00;
            err_illegal         <= 1'b0;
            err_timeout         <= 1'b0;
        end else begin
            state_q             <= state_d;
            op_reg              <= op_d;
            bus.Control_Reshape <= ctrl_d;
            wd_cnt              <= wd_d;
            if (state_q == S_GAP) begin
                cmd_count <= cmd_count + 8'h01;
            end
            // A new error in the same cycle as err_clear stays set.
            err_illegal <= (err_illegal & ~err_clear) | illegal_push;
            err_timeout <= (err_timeout & ~err_clear) | timeout_set;
        end
    end
endmodule

// File: tb/tb_reshape_cmd_sequencer.sv
// Directed bench for reshape_cmd_sequencer: a scripted reshape controller answers each issued opcode.
module tb_reshape_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       seq_enable;
    logic       err_clear;
    logic       busy;
    logic       done_pulse;
    logic       drain_irq;
    logic [7:0] cmd_count;
    logic [3:0] fifo_level;
    logic       err_illegal;
    logic       err_timeout;

    reshape_cmd_sequencer_if bus ();

    reshape_cmd_sequencer #(
        .FIFO_DEPTH (8),
        .ADDR_W     (3),
        .TIMEOUT    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .seq_enable  (seq_enable),
        .err_clear   (err_clear),
        .busy        (busy),
        .done_pulse  (done_pulse),
        .drain_irq   (drain_irq),
        .cmd_count   (cmd_count),
        .fifo_level  (fifo_level),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Observation counters, sampled 2ns after each rising edge.
    int         done_cnt, drain_cnt, gap_viol, op_starts;
    logic [3:0] prev_ctrl;

    always begin
        @(posedge clk);
        #2;
        if (rst) begin
            done_cnt  = 0;
            drain_cnt = 0;
            gap_viol  = 0;
            op_starts = 0;
            prev_ctrl = 4'h0;
        end else begin
            if ((bus.Control_Reshape != prev_ctrl) && (bus.Control_Reshape != 4'h0)) begin
                if (prev_ctrl != 4'h0) gap_viol++;
                if (bus.Control_Reshape != 4'hF) op_starts++;
            end
            prev_ctrl = bus.Control_Reshape;
            if (done_pulse) done_cnt++;
            if (drain_irq)  drain_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        seq_enable    = 1'b0;
        err_clear     = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.State     = 8'h00;
        bus.Next_Reg  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_op(input logic [3:0] op);
        bus.cmd_op    = op;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Plays the reshape controller for one command; returns at the falling edge inside GAP.
    task automatic serve(input logic [3:0] op, input string tag);
        int i;
        i = 0;
        while ((bus.Control_Reshape == 4'h0) && (i < 50)) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_issue_op"}, bus.Control_Reshape, op);
        bus.State = {4'h0, op};
        i = 0;
        while ((bus.Control_Reshape != 4'h0) && (i < 50)) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_wait_run_ctrl"}, bus.Control_Reshape, 4'h0);
        bus.State = 8'h0F;
        i = 0;
        while ((bus.Control_Reshape != 4'hF) && (i < 50)) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_release_ctrl"}, bus.Control_Reshape, 4'hF);
        bus.Next_Reg = 1'b1;
        @(negedge clk);
        bus.Next_Reg = 1'b0;
        bus.State    = 8'h00;
    endtask

    initial begin
        do_reset();

        check("rst_ctrl",        bus.Control_Reshape, 4'h0);
        check("rst_ready",       bus.cmd_ready, 1'b1);
        check("rst_busy",        busy, 1'b0);
        check("rst_level",       fifo_level, 4'd0);
        check("rst_count",       cmd_count, 8'd0);
        check("rst_done_drain",  {done_pulse, drain_irq}, 2'b00);
        check("rst_errs",        {err_illegal, err_timeout}, 2'b00);

        // Single split command, including issue latency.
        seq_enable = 1'b1;
        push_op(4'b0010);
        check("t1_level_after_push", fifo_level, 4'd1);
        check("t1_ctrl_before_pop",  bus.Control_Reshape, 4'h0);
        @(negedge clk);
        check("t1_issue_latency",    bus.Control_Reshape, 4'b0010);
        serve(4'b0010, "t1");
        check("t1_gap_done",   done_pulse, 1'b1);
        check("t1_gap_drain",  drain_irq, 1'b1);
        check("t1_gap_ctrl",   bus.Control_Reshape, 4'h0);
        repeat (2) @(negedge clk);
        check("t1_done_cnt",   done_cnt, 1);
        check("t1_drain_cnt",  drain_cnt, 1);
        check("t1_cmd_count",  cmd_count, 8'd1);
        check("t1_idle",       busy, 1'b0);

        // Three back-to-back commands issued in queue order.
        do_reset();
        seq_enable = 1'b1;
        push_op(4'b0001);
        push_op(4'b0100);
        push_op(4'b1000);
        serve(4'b0001, "t2a");
        check("t2a_no_drain", drain_irq, 1'b0);
        serve(4'b0100, "t2b");
        check("t2b_no_drain", drain_irq, 1'b0);
        serve(4'b1000, "t2c");
        check("t2c_drain",    drain_irq, 1'b1);
        repeat (2) @(negedge clk);
        check("t2_done_cnt",  done_cnt, 3);
        check("t2_drain_cnt", drain_cnt, 1);
        check("t2_cmd_count", cmd_count, 8'd3);
        check("t2_gap_viol",  gap_viol, 0);
        check("t2_op_starts", op_starts, 3);

        // Fill with sequencing disabled; the ninth push is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                check("t3_ready_at_7", bus.cmd_ready, 1'b1);
            end
            push_op(4'b0001 << (i % 4));
        end
        check("t3_ready_full", bus.cmd_ready, 1'b0);
        check("t3_level_full", fifo_level, 4'd8);
        push_op(4'b0010);
        check("t3_level_9th",  fifo_level, 4'd8);
        check("t3_no_err",     err_illegal, 1'b0);

        // Illegal opcode handling and err_clear priority.
        do_reset();
        push_op(4'b0001);
        push_op(4'b0100);
        push_op(4'b0011);
        check("t4_err_set",    err_illegal, 1'b1);
        check("t4_level",      fifo_level, 4'd2);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        check("t4_err_clear",  err_illegal, 1'b0);
        bus.cmd_op    = 4'b0000;
        bus.cmd_valid = 1'b1;
        err_clear     = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        err_clear     = 1'b0;
        check("t4_set_wins",   err_illegal, 1'b1);
        check("t4_level2",     fifo_level, 4'd2);

        // Watchdog: controller never leaves State 00 while in ISSUE.
        do_reset();
        seq_enable = 1'b1;
        push_op(4'b0100);
        for (int i = 0; i < 50; i++) begin
            if (bus.Control_Reshape != 4'h0) break;
            @(negedge clk);
        end
        check("t5_issue_op",   bus.Control_Reshape, 4'b0100);
        repeat (15) @(negedge clk);
        check("t5_no_to_15",   err_timeout, 1'b0);
        @(negedge clk);
        check("t5_to_16",      err_timeout, 1'b1);
        check("t5_ctrl_hold",  bus.Control_Reshape, 4'b0100);
        check("t5_busy",       busy, 1'b1);

        // Asynchronous reset during WAIT_RUN with three commands queued.
        bus.State = 8'h04;
        @(negedge clk);
        check("t6_wait_run",   {busy, bus.Control_Reshape}, 5'b1_0000);
        push_op(4'b0001);
        push_op(4'b0010);
        push_op(4'b1000);
        check("t6_level3",     fifo_level, 4'd3);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl",   bus.Control_Reshape, 4'h0);
        check("t6_rst_level",  fifo_level, 4'd0);
        check("t6_rst_ready",  bus.cmd_ready, 1'b1);
        check("t6_rst_busy",   busy, 1'b0);
        check("t6_rst_flags",  {done_pulse, drain_irq, err_illegal, err_timeout}, 4'b0000);
        check("t6_rst_count",  cmd_count, 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
